// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 cache with tree pseudo-LRU replacement.
// Defining L2_PERF_COUNTERS_EN builds the hit/miss counters; otherwise both ports read zero.
module l2_cache_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata256,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [1:0]   fsm_state
);
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam logic [WAY_W:0] LEAF_BASE = (WAY_W + 1)'(NUM_WAYS - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] COMPARE   = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] ALLOCATE  = 2'd3;

    logic [1:0]          state;
    logic [S_TAG-1:0]    tag_q;
    logic [S_INDEX-1:0]  idx_q;
    logic                write_q;
    logic [WAY_W-1:0]    victim_q;

    logic [255:0]        data_arr  [NUM_SETS][NUM_WAYS];
    logic [S_TAG-1:0]    tag_arr   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_arr [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_arr [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_arr  [NUM_SETS];

    logic [NUM_WAYS-1:0] match;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [255:0]        hit_line;
    logic [255:0]        merged_line;
    logic [WAY_W-1:0]    victim_way;
    logic [NUM_WAYS-2:0] plru_next;
    logic                unused_offset;

    assign unused_offset = ^mem_address[S_OFFSET-1:0];
    assign fsm_state     = state;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_match
        assign match[w] = valid_arr[idx_q][w] && (tag_arr[idx_q][w] == tag_q);
    end

    for (genvar b = 0; b < 32; b++) begin : g_merge
        assign merged_line[8*b +: 8] = mem_byte_enable256[b] ? mem_wdata256[8*b +: 8]
                                                             : hit_line[8*b +: 8];
    end

    always_comb begin : lookup
        logic [NUM_WAYS-1:0] m_scan;
        logic [NUM_WAYS-1:0] inv_scan;
        logic                inv_found;
        logic [WAY_W-1:0]    inv_way;
        logic [WAY_W:0]      node;
        logic [WAY_W-1:0]    path;
        hit       = |match;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        m_scan    = match;
        inv_scan  = ~valid_arr[idx_q];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (m_scan[0]) hit_way = WAY_W'(w);
            if (inv_scan[0] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            m_scan   = m_scan >> 1;
            inv_scan = inv_scan >> 1;
        end
        hit_line = data_arr[idx_q][hit_way];

        // Tree nodes are heap-ordered from 0; a set bit sends the victim walk right.
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, plru_arr[idx_q][node[WAY_W-1:0]]};
        end
        victim_way = inv_found ? inv_way : WAY_W'(node - LEAF_BASE);

        plru_next = plru_arr[idx_q];
        node      = '0;
        path      = hit_way;
        for (int l = 0; l < WAY_W; l++) begin
            plru_next[node[WAY_W-1:0]] = ~path[WAY_W-1];
            node = {node[WAY_W-1:0], 1'b1} + {{WAY_W{1'b0}}, path[WAY_W-1]};
            path = path << 1;
        end
    end

    always_comb begin : outputs
        mem_resp     = (state == COMPARE) && hit;
        mem_rdata256 = mem_resp ? hit_line : '0;
        pmem_write   = (state == WRITEBACK);
        pmem_read    = (state == ALLOCATE);
        pmem_wdata   = '0;
        pmem_address = '0;
        if (state == WRITEBACK) begin
            pmem_address = {tag_arr[idx_q][victim_q], idx_q, {S_OFFSET{1'b0}}};
            pmem_wdata   = data_arr[idx_q][victim_q];
        end else if (state == ALLOCATE) begin
            pmem_address = {tag_q, idx_q, {S_OFFSET{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin : ctrl
        if (!rst) begin
            state     <= IDLE;
            tag_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            victim_q  <= '0;
            valid_arr <= '{default: '0};
            dirty_arr <= '{default: '0};
            plru_arr  <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        tag_q   <= mem_address[31 -: S_TAG];
                        idx_q   <= mem_address[S_OFFSET +: S_INDEX];
                        write_q <= mem_write;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        plru_arr[idx_q] <= plru_next;
                        if (write_q) dirty_arr[idx_q][hit_way] <= 1'b1;
                        state <= IDLE;
                    end else begin
                        victim_q <= victim_way;
                        state    <= (valid_arr[idx_q][victim_way] && dirty_arr[idx_q][victim_way])
                                    ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        valid_arr[idx_q][victim_q] <= 1'b1;
                        dirty_arr[idx_q][victim_q] <= 1'b0;
                        state <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin : arrays
        if (state == COMPARE && hit && write_q) begin
            data_arr[idx_q][hit_way] <= merged_line;
        end else if (state == ALLOCATE && pmem_resp) begin
            data_arr[idx_q][victim_q] <= pmem_rdata;
            tag_arr[idx_q][victim_q]  <= tag_q;
        end
    end

`ifdef L2_PERF_COUNTERS_EN
    logic        missed_q;
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // A hit after a fill belongs to a request that already counted as a miss.
    always_ff @(posedge clk or negedge rst) begin : perf
        if (!rst) begin
            missed_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else if (state == IDLE && (mem_read || mem_write)) begin
            missed_q <= 1'b0;
        end else if (state == COMPARE) begin
            if (hit && !missed_q) hit_q <= hit_q + 32'd1;
            if (!hit) begin
                missed_q <= 1'b1;
                miss_q   <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
